// File: rtl/distance_pulse_gen.sv
// distance_pulse_gen
// Turns a raw wheel-revolution sensor into one clean ten_meter_pulse per
// 10 m travelled. The chain is: synchronizer, debouncer, revolution tick,
// revolution counter, then a pulse shaper FSM with a small backlog counter.
// Optional feature macro: DIST_PULSE_WAIT_DETECT_EN adds the idle timer that
// drives wait_en. Without the macro, wait_en is tied low.
module distance_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_WIDTH     = 4,
  parameter int WAIT_TIMEOUT    = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wheel_in,
  input  logic [7:0] pulses_per_10m,
  output logic       ten_meter_pulse,
  output logic       wait_en
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  logic             sync1_q, sync2_q;
  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             rev_tick_q, rev_tick_d;
  logic [7:0]       rev_cnt_q, rev_cnt_d;
  logic [7:0]       n_minus1;
  logic             fire;
  state_t           state_q, state_d;
  logic [PW_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic             pend_dec;
  logic             queue_fire;
  logic [2:0]       pend_q, pend_d;
  logic             pulse_q, pulse_d;

  // Debouncer: accept a new level only after an unbroken run of differing samples
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    rev_tick_d  = 1'b0;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = sync2_q;
        rev_tick_d  = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Revolution counter: ">=" compare so lowering pulses_per_10m mid-count never wraps
  always_comb begin
    n_minus1  = (pulses_per_10m == 8'd0) ? 8'd0 : pulses_per_10m - 8'd1;
    rev_cnt_d = rev_cnt_q;
    fire      = 1'b0;
    if (!en) begin
      rev_cnt_d = '0;
    end else if (rev_tick_q) begin
      if (rev_cnt_q >= n_minus1) begin
        rev_cnt_d = '0;
        fire      = 1'b1;
      end else begin
        rev_cnt_d = rev_cnt_q + 8'd1;
      end
    end
  end

  // Pulse shaper FSM: HIGH and GAP each last PULSE_WIDTH cycles; new work only while en
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    pend_dec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (fire || (pend_q != 3'd0))) begin
          state_d  = HIGH;
          ph_cnt_d = '0;
          pend_dec = (pend_q != 3'd0);
        end
      end
      HIGH: begin
        if (ph_cnt_q == PW_LAST) begin
          state_d  = GAP;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PW_W'(1);
        end
      end
      GAP: begin
        if (ph_cnt_q == PW_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PW_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase
    pulse_d = (state_d == HIGH);
  end

  // Backlog of fires that could not start immediately; saturates at 7
  always_comb begin
    pend_d     = pend_q;
    queue_fire = fire && ((state_q != IDLE) || (pend_q != 3'd0));
    if (!en) begin
      pend_d = '0;
    end else if (queue_fire && !pend_dec) begin
      if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
    end else if (pend_dec && !queue_fire) begin
      pend_d = pend_q - 3'd1;
    end
  end

  // Main state registers; reset aborts any pulse and drops the backlog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      rev_tick_q  <= 1'b0;
      rev_cnt_q   <= '0;
      state_q     <= IDLE;
      ph_cnt_q    <= '0;
      pend_q      <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= wheel_in;
      sync2_q     <= sync1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      rev_tick_q  <= rev_tick_d;
      rev_cnt_q   <= rev_cnt_d;
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      pend_q      <= pend_d;
      pulse_q     <= pulse_d;
    end
  end

  assign ten_meter_pulse = pulse_q;

`ifdef DIST_PULSE_WAIT_DETECT_EN
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(WAIT_TIMEOUT);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             wait_q, wait_d;

  // Idle timer: restarts on every revolution, saturates at the timeout
  always_comb begin
    timer_d = timer_q;
    wait_d  = 1'b0;
    if (!en || rev_tick_q) begin
      timer_d = '0;
    end else begin
      if (timer_q != TMR_MAX) timer_d = timer_q + TMR_W'(1);
      wait_d = (timer_q == TMR_MAX);
    end
  end

  // Idle timer and vehicle-stopped flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      wait_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_en = wait_q;
`else
  assign wait_en = 1'b0;
`endif

endmodule
